// File: rtl/subtractor_serial.sv
// Bit-serial WIDTH-bit subtractor: DIFF = A - B - B0, one bit per clock, LSB first.
// Start/busy/done handshake; results hold until the next completed operation.
module subtractor_serial #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] DIFF,
  output logic             Borrow,
  output logic             Overflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic            accept;
  logic            last;

  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             amsb;
  logic             bmsb;

  logic             a_bit, b_bit, d, br_next;
  logic [WIDTH-1:0] diff_full;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             overflow_q;

  assign last = (cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and acceptance of a new operation.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One full-subtractor bit slice on the current LSBs.
  always_comb begin
    a_bit     = areg[0];
    b_bit     = breg[0];
    d         = a_bit ^ b_bit ^ br;
    br_next   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    diff_full = {d, areg[WIDTH-1:1]};
  end

  // Serial datapath: operand shift, borrow chain, bit counter.
  // The partial difference shares the A register: each consumed A bit at the
  // LSB frees a slot that the new difference bit fills from the MSB side, so
  // after WIDTH shifts the register holds the complete result.
  always_ff @(posedge clk) begin
    if (rst) begin
      areg <= '0;
      breg <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      amsb <= 1'b0;
      bmsb <= 1'b0;
    end else if (accept) begin
      areg <= A;
      breg <= B;
      br   <= B0;
      cnt  <= '0;
      amsb <= A[WIDTH-1];
      bmsb <= B[WIDTH-1];
    end else if (state == SHIFT) begin
      areg <= diff_full;
      breg <= {1'b0, breg[WIDTH-1:1]};
      br   <= br_next;
      cnt  <= cnt + 1'b1;
    end
  end

  // Result registers update only on the final bit-cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else if (state == SHIFT && last) begin
      diff_q     <= diff_full;
      borrow_q   <= br_next;
      overflow_q <= (amsb != bmsb) && (d != amsb);
    end
  end

  // Status flags decoded from the registered state.
  always_comb begin
    busy     = (state == SHIFT);
    done     = (state == DONE);
    DIFF     = diff_q;
    Borrow   = borrow_q;
    Overflow = overflow_q;
  end

endmodule

// File: tb/tb_subtractor_serial.sv
// Self-checking bench for subtractor_serial with an arithmetic reference model.
module tb_subtractor_serial;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B;
  logic         B0;
  logic         busy, done;
  logic [W-1:0] DIFF;
  logic         Borrow, Overflow;

  int total = 0;
  int bad   = 0;

  // Previously completed result, expected to stay visible during SHIFT.
  logic [W-1:0] hold_diff;
  logic         hold_borrow;
  logic         hold_ovf;

  subtractor_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .B0(B0),
    .busy(busy), .done(done), .DIFF(DIFF), .Borrow(Borrow), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic b0,
                       output logic [W-1:0] ed, output logic eb, output logic eo);
    int u, s;
    u  = int'(a) - int'(b) - int'(b0);
    s  = int'($signed(a)) - int'($signed(b)) - int'(b0);
    ed = W'(u);
    eb = (u < 0);
    eo = (s > (2**(W-1)) - 1) || (s < -(2**(W-1)));
  endtask

  // Called at a negedge in IDLE or DONE; returns at the negedge of the first SHIFT cycle.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic b0);
    A = a; B = b; B0 = b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); B0 = 1'($urandom);
  endtask

  // Walks the SHIFT cycles and ends at the negedge of the done cycle.
  task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic b0,
                           input bit poke);
    logic [W-1:0] ed;
    logic eb, eo;
    model(a, b, b0, ed, eb, eo);
    for (int unsigned i = 0; i < W; i++) begin
      check("busy_shift", 32'(busy), 32'd1);
      check("done_shift", 32'(done), 32'd0);
      check("diff_hold", 32'(DIFF), 32'(hold_diff));
      check("borrow_hold", 32'(Borrow), 32'(hold_borrow));
      check("ovf_hold", 32'(Overflow), 32'(hold_ovf));
      start = (poke && i == 1);
      if (poke && i == 1) begin A = '1; B = '1; B0 = 1'b1; end
      @(negedge clk);
      start = 1'b0;
    end
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("diff", 32'(DIFF), 32'(ed));
    check("borrow", 32'(Borrow), 32'(eb));
    check("overflow", 32'(Overflow), 32'(eo));
    hold_diff = ed; hold_borrow = eb; hold_ovf = eo;
  endtask

  // Single operation ending back in IDLE with done checked as a one-cycle pulse.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic b0);
    issue(a, b, b0);
    finish_op(a, b, b0, 1'b0);
    @(negedge clk);
    check("done_once", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic rb0;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; B0 = 1'b0;
    hold_diff = '0; hold_borrow = 1'b0; hold_ovf = 1'b0;

    // Reset for two cycles.
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(DIFF), 32'd0);
    check("rst_borrow", 32'(Borrow), 32'd0);
    check("rst_ovf", 32'(Overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    op(4'd9, 4'd3, 1'b0);
    op(4'd3, 4'd9, 1'b0);
    op(4'd8, 4'd1, 1'b0);
    op(4'd0, 4'd0, 1'b1);

    // start during SHIFT is ignored.
    issue(4'd5, 4'd2, 1'b0);
    finish_op(4'd5, 4'd2, 1'b0, 1'b1);
    @(negedge clk);
    check("poke_done_once", 32'(done), 32'd0);

    // Back-to-back: start held high through DONE.
    issue(4'd12, 4'd5, 1'b1);
    finish_op(4'd12, 4'd5, 1'b1, 1'b0);
    issue(4'd7, 4'd7, 1'b0);
    finish_op(4'd7, 4'd7, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b_done_once", 32'(done), 32'd0);

    // Abort with reset in the second SHIFT cycle.
    issue(4'd12, 4'd4, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(DIFF), 32'd0);
    check("abort_borrow", 32'(Borrow), 32'd0);
    check("abort_ovf", 32'(Overflow), 32'd0);
    hold_diff = '0; hold_borrow = 1'b0; hold_ovf = 1'b0;
    for (int unsigned i = 0; i < W + 3; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
    end

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1; A = 4'd6; B = 4'd1; B0 = 1'b0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_vs_start", 32'(busy), 32'd0);
    @(negedge clk);
    check("rst_vs_start_idle", 32'(busy), 32'd0);

    // Randomized operations, alternating isolated and chained.
    for (int unsigned n = 0; n < 24; n++) begin
      ra = W'($urandom); rb = W'($urandom); rb0 = 1'($urandom);
      if (n % 3 == 2) begin
        issue(ra, rb, rb0);
        finish_op(ra, rb, rb0, 1'b0);
        ra = W'($urandom); rb = W'($urandom); rb0 = 1'($urandom);
        op(ra, rb, rb0);
      end else begin
        op(ra, rb, rb0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
